// File: rtl/digit_mul_pkg.sv
// Shared types and constants for the digit-serial multiplier sequencer.
package digit_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W = 2;
  localparam int PP_W    = 4;

  // Digit counter width; at least one bit so WIDTH=2 still has a legal counter.
  function automatic int cnt_w(input int digits);
    int w;
    w = 1;
    while ((1 << w) < digits) w++;
    return w;
  endfunction

endpackage

// File: rtl/digit_mul2x2.sv
// Combinational 2-bit x 2-bit -> 4-bit unsigned digit multiplier.
module digit_mul2x2
  import digit_mul_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  output logic [PP_W-1:0]    p
);

  assign p = PP_W'(x) * PP_W'(y);

endmodule

// File: rtl/digit_serial_mul_ctrl.sv
// WIDTH x WIDTH unsigned multiplier built from one time-shared 2x2 digit multiplier.
// Optional whole-operand zero shortcut: DIGIT_MUL_ZERO_SKIP_EN.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid is never withdrawn by this block before its transfer, and data is
// held stable while valid is high and ready is low.
module digit_serial_mul_ctrl
  import digit_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output state_t             state_dbg
);

  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int CW     = cnt_w(DIGITS);
  localparam int AW     = 2 * WIDTH;
  localparam int SW     = CW + 2;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t state, state_next;

  logic [DIGITS-1:0][DIGIT_W-1:0] a_r, b_r;
  logic [AW-1:0] acc, acc_sum, pp_sh;
  logic [CW-1:0] i_r, j_r;
  logic [PP_W-1:0] pp;
  logic [SW-1:0] sh;
  logic last_pair, zero_op;

  digit_mul2x2 u_mul (
    .x (a_r[i_r]),
    .y (b_r[j_r]),
    .p (pp)
  );

  // Digit pair (i, j) carries weight 4^(i+j).
  assign sh        = {1'b0, i_r, 1'b0} + {1'b0, j_r, 1'b0};
  assign pp_sh     = AW'(pp) << sh;
  assign acc_sum   = acc + pp_sh;
  assign last_pair = (i_r == LAST) && (j_r == LAST);

`ifdef DIGIT_MUL_ZERO_SKIP_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = zero_op ? DONE : RUN;
      RUN:  if (last_pair) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      i_r     <= '0;
      j_r     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
            acc <= '0;
            i_r <= '0;
            j_r <= '0;
            if (zero_op) product <= '0;
          end
        end
        RUN: begin
          acc <= acc_sum;
          if (j_r == LAST) begin
            j_r <= '0;
            i_r <= i_r + 1'b1;
          end else begin
            j_r <= j_r + 1'b1;
          end
          if (last_pair) product <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_mul_ctrl.sv
// Self-checking bench for digit_serial_mul_ctrl: directed cases plus random operands
// compared against a plain-arithmetic product/latency model.
module tb_digit_serial_mul_ctrl;
  import digit_mul_pkg::*;

  localparam int W       = 8;
  localparam int DIGITS  = W / 2;
  localparam int RUN_CYC = DIGITS * DIGITS;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;
  state_t         state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_ops    = 0;
  int n_acc    = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_p;

  digit_serial_mul_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && in_valid && in_ready) n_acc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int exp_latency(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef DIGIT_MUL_ZERO_SKIP_EN
    if (av == 0 || bv == 0) return 1;
`endif
    return RUN_CYC + 1;
  endfunction

  // gmode: 0 = in_valid low after accept, 1 = random in_valid/a/b noise, 2 = in_valid held high
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int gmode, input int hold);
    int lat, busy_n, exp_lat;
    bit done;
    logic [2*W-1:0] exp_p;
    check("idle_ready", in_ready, 1);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    out_ready = (hold == 0);
    exp_q.push_back({{W{1'b0}}, av} * {{W{1'b0}}, bv});
    n_ops++;
    exp_lat = exp_latency(av, bv);
    lat = 0;
    busy_n = 0;
    done = 1'b0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        done = 1'b1;
      end else begin
        if (busy) busy_n++;
        check("run_in_ready", in_ready, 0);
        check("run_product_kept", product, last_p);
        if (gmode == 1) begin
          in_valid = 1'($urandom_range(0, 1));
          a = W'($urandom);
          b = W'($urandom);
        end else if (gmode == 0) begin
          in_valid = 1'b0;
        end
      end
    end
    check("latency", lat, exp_lat);
    check("busy_cycles", busy_n, exp_lat - 1);
    exp_p = exp_q.pop_front();
    check("product", product, exp_p);
    in_valid = (gmode == 2);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_product", product, exp_p);
      if (gmode == 1) begin
        in_valid = 1'($urandom_range(0, 1));
        a = W'($urandom);
        b = W'($urandom);
      end
    end
    in_valid  = (gmode == 2);
    a         = av;
    b         = bv;
    out_ready = 1'b1;
    @(negedge clk);
    check("after_in_ready", in_ready, 1);
    check("after_out_valid", out_valid, 0);
    check("product_kept", product, exp_p);
    last_p = exp_p;
  endtask

  task automatic reset_mid_run();
    check("idle_ready_pre_rst", in_ready, 1);
    in_valid  = 1'b1;
    a         = 8'd7;
    b         = 8'd9;
    out_ready = 1'b1;
    n_ops++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("mid_rst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_product", product, 0);
    last_p = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'd2, 8'd2, 0, 0);
  endtask

  initial begin
    logic [W-1:0] av, bv;
    int sel;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    last_p    = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'd3, 8'd5, 0, 0);
    run_op(8'd255, 8'd255, 0, 0);
    run_op(8'd200, 8'd123, 1, 10);
    run_op(8'd0, 8'd77, 0, 0);
    run_op(8'd77, 8'd0, 1, 2);
    run_op(8'd10, 8'd10, 2, 0);
    run_op(8'd12, 8'd11, 2, 0);
    in_valid = 1'b0;
    @(negedge clk);

    reset_mid_run();

    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      av = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : W'($urandom);
      sel = $urandom_range(0, 9);
      bv = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : W'($urandom);
      run_op(av, bv, $urandom_range(0, 1),
             ($urandom_range(0, 3) == 3) ? $urandom_range(1, 4) : 0);
    end

    check("accept_count", n_acc, n_ops);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/digit_serial_mul_ctrl.md
Name: digit_serial_mul_ctrl

Overview:
- Sequencer that computes a WIDTH x WIDTH unsigned product by time-sharing one 2-bit x 2-bit digit multiplier.
- Walks every (i, j) digit pair of the operands, shifts each 4-bit partial product and accumulates it.
- Sits between the lab top level (switch/register inputs) and the LED/seven-segment result path.
- Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2; DIGITS = WIDTH/2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair a/b presented
- in_ready  out  1  block can accept operands; high only in IDLE
- a  in  WIDTH  multiplicand, unsigned
- b  in  WIDTH  multiplier, unsigned
- out_valid  out  1  product valid; high only in DONE
- out_ready  in  1  consumer accepts product
- product  out  2*WIDTH  unsigned result
- busy  out  1  high in RUN

Behaviour:
- Reset (async, rst_n low): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, accumulator=0, digit counters i=j=0. Reset mid-RUN or mid-DONE abandons the operation with no output.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a and b into internal registers, clear accumulator, set i=j=0, go to RUN.
  - a/b changes after acceptance have no effect.
- RUN, one digit pair per cycle:
  - p = a_r[2i+1:2i] * b_r[2j+1:2j], 4-bit result from the digit multiplier.
  - acc <= acc + (p << 2*(i+j)), computed at 2*WIDTH bits; no overflow is possible.
  - j increments; on j=DIGITS-1, j wraps to 0 and i increments.
  - After pair (DIGITS-1, DIGITS-1), go to DONE.
  - in_valid is ignored (in_ready=0).
- DONE:
  - out_valid=1; product shows the final accumulator and holds stable while out_ready=0.
  - On out_ready=1: transfer completes that cycle; next state IDLE, out_valid=0.
  - No same-cycle DONE->accept: in_ready rises the cycle after the handshake.
- Latency, counted from the in_valid & in_ready edge to the first out_valid cycle: DIGITS*DIGITS + 1 cycles (17 for WIDTH=8).
- Maximum throughput: one result per DIGITS*DIGITS + 2 cycles.
- product register updates only on entry to DONE. It keeps its last value in IDLE/RUN and is 0 after reset.
- WIDTH=2 degenerate case: one RUN cycle.

Optional Feature:
- Macro: DIGIT_MUL_ZERO_SKIP_EN.
- Defined:
  - In IDLE, if the accepted a==0 or b==0, go directly to DONE with product=0; latency 1 cycle.
  - In RUN, a pair whose a digit or b digit is zero still consumes one cycle (fixed schedule). Only the whole-operand shortcut changes timing.
- Not defined: every operation takes the full DIGITS*DIGITS RUN cycles, zero operands included.

Decomposition:
- Shared package digit_mul_pkg:
  - state enum (IDLE, RUN, DONE)
  - DIGIT_W=2 and PP_W=4 constants
  - function for counter width clog2(DIGITS)
- Sub-module digit_mul2x2: purely combinational 2-bit x 2-bit -> 4-bit unsigned multiplier, instantiated once. All sequencing, shifting and accumulation stay in digit_serial_mul_ctrl.

Test Plan:
- WIDTH=8, a=3, b=5, out_ready=1 -> busy for 16 cycles, out_valid 17 cycles after accept, product=15, in_ready high the cycle after transfer.
- a=255, b=255 -> product=65025. Exhaustive a,b in 0..255 against a reference model: every result exact, latency constant at 17.
- a=200, b=123 with out_ready held 0 for 10 cycles -> out_valid stays high, product=24600 stable throughout; in_valid pulses during RUN/DONE are ignored (no second accept).
- Accept a=7, b=9, then drop rst_n low during RUN cycle 5 -> outputs immediately reset values; after release, a=2, b=2 -> product=4 with normal latency, no residue.
- With DIGIT_MUL_ZERO_SKIP_EN: a=0, b=77 -> out_valid 1 cycle after accept, product=0. Without the macro, the same stimulus gives product=0 after 17 cycles.
- Back-to-back: in_valid held high with a=10,b=10 then a=12,b=11 -> products 100 then 132, each accepted exactly once; gap of one IDLE cycle between out_valid and the next acceptance.
